sha256_block_word_streamer_320: RTL
===================================

Name: sha256_block_word_streamer_320

Overview:
- Reader side of the 320-bit message block register.
- On a start pulse it captures the 320-bit block and streams it as big-endian 32-bit words to the SHA-256 message expander, using a valid/ready handshake.
- With padding enabled it appends the SHA-256 padding for a 320-bit message, so the consumer receives exactly one complete 512-bit block (16 words).

Parameters:
- PAD_EN, 1, 1 = emit 10 data words plus 6 padding words (16 total); 0 = emit the 10 data words only.
- MSG_LEN_BITS, 320, value placed in the final padding word (message length field, low 32 bits; high 32 bits are 0).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- start  input  1  load request; sampled only in IDLE.
- block_in  input  320  message block; word k = block_in[319-32k -: 32].
- word_out  output  32  current word.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  consumer accepts word_out.
- word_idx  output  4  index of the current word (0..15).
- word_last  output  1  current word is the final word of the block.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse after the final word is transferred.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE; the internal 320-bit buffer and word counter clear to 0.
  - Outputs reset to: word_out=0, word_valid=0, word_idx=0, word_last=0, busy=0, done=0.
- Word count: NW = 16 if PAD_EN=1, else 10.
- States:
  - IDLE to STREAM when start=1. On that edge: buffer <= block_in, counter <= 0.
  - STREAM to IDLE on the handshake (word_valid & word_ready) where counter = NW-1.
- Latency: start sampled at edge N; word_valid=1 with word 0 from edge N+1.
- STREAM outputs:
  - word_valid=1 and busy=1 throughout.
  - word_idx = counter.
  - word_last = (counter = NW-1).
- word_out selection:
  - counter 0..9: buffer[319-32*counter -: 32].
  - counter 10: 32'h80000000.
  - counter 11..14: 32'h00000000.
  - counter 15: MSG_LEN_BITS[31:0].
- Handshake:
  - A transfer occurs when word_valid & word_ready are both high at a rising edge; counter then increments.
  - Without ready, word_out, word_idx and word_last hold stable; word_valid never drops mid-block.
  - word_out may depend combinationally on the counter but never on word_ready.
- Completion:
  - On the final transfer edge: state goes to IDLE, word_valid=0, done=1 for exactly one cycle.
  - done is high in the first IDLE cycle. A start in that same cycle is accepted, giving back-to-back blocks with one bubble cycle.
- start while busy is ignored. block_in changes during STREAM have no effect, because the block is captured.
- Reset mid-stream aborts immediately; no done pulse follows. After release the next start begins at word 0.
- word_ready while word_valid=0 has no effect.
- Counter never wraps within a block; it is reloaded to 0 on each accepted start.

Test Plan:
- Reset, then start with block_in = {32'h00000001, 32'h00000002, ..., 32'h0000000A}, word_ready held 1 -> words 1..10 appear on consecutive cycles, then 80000000, 0, 0, 0, 0, 00000140. word_last is high only at idx 15. done pulses once, in the cycle after idx 15. busy is high for exactly 16 cycles.
- Same block with word_ready toggling 1,0,0,1,... -> identical word sequence and no word skipped or duplicated. word_out and word_idx are held stable during every stalled cycle.
- PAD_EN=0, block_in = 320'hFFFF...FF -> exactly 10 words of FFFFFFFF; word_last at idx 9; done pulse after it.
- A start pulse at idx 4 with a different block_in, plus block_in changed mid-stream -> output is unaffected and still the originally captured block. A start asserted in the done cycle -> second block begins on the next cycle at idx 0.
- RST pulled low at idx 7 -> all outputs 0 asynchronously, with no done pulse. After release, a new start streams from idx 0 with the new block.

Source files
------------

// File: rtl/sha256_block_word_streamer_320.sv
// Captures a 320-bit message block on start and streams it as big-endian 32-bit
// words over valid/ready, optionally followed by the SHA-256 padding words.
module sha256_block_word_streamer_320 #(
  parameter bit          PAD_EN       = 1'b1,
  parameter int unsigned MSG_LEN_BITS = 320
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [319:0] block_in,
  output logic [31:0]  word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [3:0]   word_idx,
  output logic         word_last,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0]  LAST_IDX = PAD_EN ? 4'd15 : 4'd9;
  localparam logic [31:0] LEN_WORD = 32'(MSG_LEN_BITS);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state, state_nx;
  logic [319:0]   buf_q;
  logic [3:0]     cnt;
  logic           done_q;
  logic           xfer;
  logic           at_last;

  // Data words come from the captured buffer; indices 10..15 are the fixed
  // padding: the 1-bit marker, zero fill, then the message length.
  function automatic logic [31:0] sel_word(input logic [319:0] b, input logic [3:0] c);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 10; k++) begin
      if (c == 4'(k)) w = b[319 - 32*k -: 32];
    end
    if (c == 4'd10) w = 32'h8000_0000;
    if (c == 4'd15) w = LEN_WORD;
    return w;
  endfunction

  assign xfer    = (state == STREAM) && word_ready;
  assign at_last = (cnt == LAST_IDX);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = STREAM;
      STREAM:  if (xfer && at_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // The counter parks on the last index after the final transfer; the next
  // accepted start reloads it, so it never wraps inside a block.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_q  <= '0;
      cnt    <= 4'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer && at_last;
      if (state == IDLE && start) begin
        buf_q <= block_in;
        cnt   <= 4'd0;
      end else if (xfer && !at_last) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  always_comb begin
    word_out   = 32'h0;
    word_idx   = 4'd0;
    word_last  = 1'b0;
    word_valid = 1'b0;
    busy       = 1'b0;
    if (state == STREAM) begin
      word_out   = sel_word(buf_q, cnt);
      word_idx   = cnt;
      word_last  = at_last;
      word_valid = 1'b1;
      busy       = 1'b1;
    end
  end

  assign done = done_q;

endmodule
